long_multiplier: RTL and testbench

- Sequential shift-add multiplier-accumulator that computes D = Q*M + R.
- It is the inverse of the long divider: it rebuilds the dividend from quotient, divisor and remainder.
- Used as the reconstruction engine in divider self-check and round-trip datapaths.
- Processes one quotient bit per clock, with a valid/ready handshake on both input and output.

---
 rtl/long_multiplier.sv | 116 +++++++++++
 tb/tb_long_multiplier.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/long_multiplier.sv
// Sequential shift-add multiply-accumulate D = Q*M + R, one multiplier bit per clock.
// Optional operand check (err = R >= M) is enabled by defining LONG_MULTIPLIER_REM_CHECK_EN.
module long_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   M,
  input  logic [WIDTH-1:0]   Q,
  input  logic [WIDTH-1:0]   R,
  output logic               in_ready,
  output logic               busy,
  output logic [2*WIDTH-1:0] D,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] addend;

  // Partial product for the current multiplier bit, widened so no carry is lost.
  assign addend = q_q[cnt_q] ? ({{WIDTH{1'b0}}, m_q} << cnt_q) : '0;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = M;
          q_d     = Q;
          acc_d   = {{WIDTH{1'b0}}, R};
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_q + addend;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          d_d     = acc_d;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments and an async active-low reset clearing every register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
    end
  end

`ifdef LONG_MULTIPLIER_REM_CHECK_EN
  logic err_q, err_d;

  // A valid remainder is strictly below the divisor; M=0 always flags.
  always_comb begin
    err_d = err_q;
    if (state_q == S_IDLE && start)          err_d = (R >= M);
    else if (state_q == S_DONE && out_ready) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN);
  assign out_valid = (state_q == S_DONE);
  assign D         = d_q;

endmodule

// File: tb/tb_long_multiplier.sv
// Self-checking bench for long_multiplier: directed literal cases plus randomized ops
// compared every cycle against a transaction-level model (D = Q*M + R, WIDTH-cycle latency).
module tb_long_multiplier;

  localparam int W = 4;
`ifdef LONG_MULTIPLIER_REM_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   M = '0, Q = '0, R = '0;
  logic           in_ready, busy, out_valid, err;
  logic [2*W-1:0] D;
  logic           out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  long_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .M(M), .Q(Q), .R(R),
    .in_ready(in_ready), .busy(busy), .D(D),
    .out_valid(out_valid), .out_ready(out_ready), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one op in flight, result appears W edges after acceptance.
  bit          m_busy_op;
  int unsigned m_age;
  int          m_d;
  bit          m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy_op <= 1'b0;
      m_age     <= 0;
      m_err     <= 1'b0;
    end else if (!m_busy_op) begin
      if (start) begin
        m_busy_op <= 1'b1;
        m_age     <= 0;
        m_d       <= int'(Q) * int'(M) + int'(R);
        m_err     <= ERR_EN && (R >= M);
      end
    end else if (m_age < W) begin
      m_age <= m_age + 1;
    end else if (out_ready) begin
      m_busy_op <= 1'b0;
      m_err     <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_in_ready", in_ready, !m_busy_op);
      check("model_busy", busy, m_busy_op && m_age < W);
      check("model_out_valid", out_valid, m_busy_op && m_age == W);
      if (out_valid) begin
        check("model_D", D, m_d);
        check("model_err", err, m_err);
      end
      if (!m_busy_op) check("model_err_idle", err, 0);
    end
  end

  task automatic do_op(input int q, input int m, input int r, input int exp_d,
                       input bit exp_e, input int hold, input bit poke);
    int n;
    @(negedge clk);
    Q = W'(q); M = W'(m); R = W'(r); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    check("in_ready_fall", in_ready, 0);
    check("busy_rise", busy, 1);
    while (!out_valid && n < 20) begin
      if (poke && n == 1) begin
        Q = W'(1); M = W'(1); R = W'(0); start = 1'b1;
      end else begin
        Q = W'($urandom_range(15, 0)); M = W'($urandom_range(15, 0));
        R = W'($urandom_range(15, 0));
      end
      out_ready = 1'(($urandom_range(1, 0)));
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    out_ready = 1'b0;
    check("latency", n, W);
    check("D_value", D, exp_d);
    check("err_value", err, exp_e);
    for (int i = 0; i < hold; i++) begin
      if (poke && i == 0) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("hold_valid", out_valid, 1);
      check("hold_D", D, exp_d);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    start = poke;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    check("hs_valid_fall", out_valid, 0);
    check("hs_in_ready", in_ready, 1);
    @(negedge clk);
    check("single_delivery", out_valid, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_D", D, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;

    do_op(5, 3, 2, 17, 1'b0, 0, 1'b0);
    do_op(15, 15, 14, 239, 1'b0, 0, 1'b0);
    do_op(15, 15, 15, 240, ERR_EN, 0, 1'b0);
    do_op(0, 9, 7, 7, 1'b0, 0, 1'b0);
    do_op(4, 0, 0, 0, ERR_EN, 0, 1'b0);
    do_op(6, 6, 1, 37, 1'b0, 5, 1'b0);
    do_op(5, 3, 2, 17, 1'b0, 2, 1'b1);

    // Async reset in the middle of RUN.
    @(negedge clk);
    Q = W'(5); M = W'(3); R = W'(2); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_in_ready", in_ready, 1);
    check("async_busy", busy, 0);
    check("async_out_valid", out_valid, 0);
    check("async_D", D, 0);
    check("async_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(3, 2, 1, 7, 1'b0, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      int q, m, r;
      q = int'($urandom_range(15, 0));
      m = int'($urandom_range(15, 0));
      r = int'($urandom_range(15, 0));
      do_op(q, m, r, q * m + r, ERR_EN && (r >= m), int'($urandom_range(3, 0)),
            1'(($urandom_range(1, 0))));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
